scan_phase_gen: RTL
===================

# scan_phase_gen

Parametrised scan-phase generator for multiplexed outputs such as 7-segment digit scanning and LED matrix rows. It divides `clk` into equal phase slots, cycles a phase index through `PHASES` values, and drives one-hot selects, an inter-phase blanking window, and per-phase and per-frame strobes. It supports run/hold, synchronous restart and single-step advance for debug. It sits between the system clock and the display driver and replaces fixed 4-phase dividers.

## Interface
- `DIV`, 20000: clocks per phase slot; must be ≥ 2.
- `PHASES`, 4: number of phases; must be ≥ 2.
- `BLANK`, 16: blanking clocks at the start of each slot; must be < `DIV`. A value of 0 disables blanking.
- `CNT_W` (derived, not overridable): `$clog2(DIV)`.
- `SEL_W` (derived, not overridable): `$clog2(PHASES)`.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run enable. When low, the block holds its state.
- `clr` in 1: synchronous restart to phase 0, slot start.
- `step` in 1: single-cycle advance; honoured only while `en`=0.
- `phase_sel` out SEL_W: current phase index.
- `phase_onehot` out PHASES: one-hot decode of `phase_sel`.
- `blank` out 1: high during the first `BLANK` clocks of each slot.
- `phase_tick` out 1: one-cycle pulse on the first cycle of a new phase.
- `frame_tick` out 1: one-cycle pulse on the first cycle of phase 0 after a wrap.

## Operation
- Internal slot counter `cnt` (CNT_W bits) counts 0..DIV-1. The phase register counts 0..PHASES-1 and wraps to 0.
- All outputs are registers. There is no combinational path from inputs to outputs.
- Priority per edge: reset > `clr` > `en` > `step`.
- `clr`=1:
  - `cnt`←0, phase←0.
  - `phase_tick`←0, `frame_tick`←0.
  - `blank`←(BLANK>0).
- `en`=1, `cnt`<DIV-1: `cnt`←`cnt`+1. `blank`←(`cnt`+1 < BLANK). Ticks←0.
- `en`=1, `cnt`=DIV-1:
  - `cnt`←0, phase←(phase=PHASES-1 ? 0 : phase+1).
  - `phase_tick`←1; `frame_tick`←1 only if the new phase is 0.
  - `blank`←(BLANK>0).
- `en`=0, `step`=1: same update as the `cnt`=DIV-1 case, regardless of the current `cnt`.
- `en`=0, `step`=0: `cnt`, phase and `blank` hold. Ticks←0.
- `step` while `en`=1 is ignored.
- `phase_onehot` is registered alongside `phase_sel`. Bit *i* is set iff `phase_sel`=*i*, and exactly one bit is always set.
- Reset values: `cnt`=0, `phase_sel`=0, `phase_onehot`=1, `blank`=(BLANK>0), `phase_tick`=0, `frame_tick`=0.
- Arithmetic is unsigned. Compares against DIV-1 and PHASES-1 are exact, so non-power-of-two values wrap correctly. No overflow states are reachable.

## Timing
- With `en` held high from reset release:
  - Phase 0 lasts DIV cycles. Every subsequent phase also lasts DIV cycles.
  - The frame period is PHASES×DIV cycles.
- `phase_tick` and `frame_tick` are high in the same cycle that `phase_sel` first shows the new value.
- `blank` rises in the same cycle as the phase change and stays high for exactly BLANK cycles while enabled.
- A hold (`en`=0) stretches the current slot by the hold length. No tick is emitted during a hold.
- `clr` coincident with a wrap: `clr` wins. No tick is emitted.
- A reset assertion clears all state immediately (asynchronously). Release is sampled on the next rising edge.

## Structure
- The shared display package holds the `DIV`, `PHASES` and `BLANK` default constants so that scan drivers agree.
- A single flat module. The counter, phase register and one-hot decode are inline; no sub-module is needed.
- Elaboration-time assertions check the parameter constraints.

## Test plan
Parameters for all scenarios: DIV=5, PHASES=3, BLANK=2.
1. Release reset, `en`=1 → `phase_sel` follows 0,1,2,0, changing at cycles 5, 10 and 15. `phase_tick` pulses at 5, 10 and 15. `frame_tick` pulses only at 15. `phase_onehot` follows 001, 010, 100, 001.
2. Free run → `blank` is high at slot cycles 0–1 and low at 2–4 in every phase. Re-run with BLANK=0 → `blank` stays low throughout.
3. Drop `en` at `cnt`=3 for 7 cycles, then raise it → all outputs hold during the hold. The next `phase_tick` comes exactly 2 enabled cycles after re-enable.
4. Assert `clr` at phase 2, `cnt`=4 (coincident with a wrap) → next cycle shows phase 0 with `phase_tick`=0 and `frame_tick`=0. The following `phase_tick` comes 5 cycles later.
5. With `en`=0, pulse `step` three times → each pulse advances the phase with a `phase_tick`, and the third pulse also gives `frame_tick`. A `step` pulse with `en`=1 produces no extra tick.
6. Assert `rst_n`=0 mid-slot, between clock edges → outputs immediately become 0, 001, 1, 0, 0. Normal run resumes after release.

Source files
------------

// File: rtl/scan_phase_gen_pkg.sv
// Shared display-scan constants so every scan driver agrees on slot length,
// phase count and blanking width.
package scan_phase_gen_pkg;

  localparam int DIV_DEFAULT    = 20000;
  localparam int PHASES_DEFAULT = 4;
  localparam int BLANK_DEFAULT  = 16;

endpackage : scan_phase_gen_pkg

// File: rtl/scan_phase_gen_if.sv
// Control and scan-output bundle between a display controller (master) and the
// phase generator (slave).
interface scan_phase_gen_if
  import scan_phase_gen_pkg::*;
#(
  parameter int PHASES = PHASES_DEFAULT
);

  localparam int SEL_W = $clog2(PHASES);

  logic              en;
  logic              clr;
  logic              step;
  logic [SEL_W-1:0]  phase_sel;
  logic [PHASES-1:0] phase_onehot;
  logic              blank;
  logic              phase_tick;
  logic              frame_tick;

  modport master (
    output en, clr, step,
    input  phase_sel, phase_onehot, blank, phase_tick, frame_tick
  );

  modport slave (
    input  en, clr, step,
    output phase_sel, phase_onehot, blank, phase_tick, frame_tick
  );

endinterface : scan_phase_gen_if

// File: rtl/scan_phase_gen.sv
// Scan-phase generator: divides clk into DIV-cycle slots, cycles PHASES phase
// indices and produces one-hot selects, slot-start blanking and tick strobes.
module scan_phase_gen
  import scan_phase_gen_pkg::*;
#(
  parameter int DIV    = DIV_DEFAULT,
  parameter int PHASES = PHASES_DEFAULT,
  parameter int BLANK  = BLANK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_phase_gen_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV);
  localparam int SEL_W = $clog2(PHASES);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_C  = CNT_W'(BLANK);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(PHASES - 1);
  localparam logic              BLANK_EN = (BLANK > 0) ? 1'b1 : 1'b0;
  localparam logic [PHASES-1:0] OH_ONE   = PHASES'(1);

  if (DIV < 2) begin : g_bad_div
    $error("scan_phase_gen: DIV must be >= 2");
  end
  if (PHASES < 2) begin : g_bad_phases
    $error("scan_phase_gen: PHASES must be >= 2");
  end
  if ((BLANK < 0) || (BLANK >= DIV)) begin : g_bad_blank
    $error("scan_phase_gen: BLANK must be in 0..DIV-1");
  end

  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [SEL_W-1:0]  phase_q,      phase_d;
  logic [PHASES-1:0] onehot_q,     onehot_d;
  logic              blank_q,      blank_d;
  logic              phase_tick_q, phase_tick_d;
  logic              frame_tick_q, frame_tick_d;

  logic [CNT_W-1:0]  cnt_inc_s;
  logic [SEL_W-1:0]  phase_nxt_s;

  // Next-state selection: clr beats en, en beats step; ticks default low.
  always_comb begin
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    blank_d      = blank_q;
    phase_tick_d = 1'b0;
    frame_tick_d = 1'b0;
    cnt_inc_s    = cnt_q + CNT_W'(1);
    phase_nxt_s  = (phase_q == SEL_LAST) ? '0 : phase_q + SEL_W'(1);

    if (bus.clr) begin
      cnt_d   = '0;
      phase_d = '0;
      blank_d = BLANK_EN;
    end else if (bus.en && (cnt_q != CNT_LAST)) begin
      cnt_d   = cnt_inc_s;
      blank_d = (cnt_inc_s < BLANK_C);
    end else if (bus.en || bus.step) begin
      // slot wrap while running, or a debug step while halted
      cnt_d        = '0;
      phase_d      = phase_nxt_s;
      phase_tick_d = 1'b1;
      frame_tick_d = (phase_nxt_s == '0);
      blank_d      = BLANK_EN;
    end else begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
    end

    onehot_d = OH_ONE << phase_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      phase_q      <= '0;
      onehot_q     <= OH_ONE;
      blank_q      <= BLANK_EN;
      phase_tick_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      onehot_q     <= onehot_d;
      blank_q      <= blank_d;
      phase_tick_q <= phase_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.phase_sel    = phase_q;
  assign bus.phase_onehot = onehot_q;
  assign bus.blank        = blank_q;
  assign bus.phase_tick   = phase_tick_q;
  assign bus.frame_tick   = frame_tick_q;

endmodule : scan_phase_gen
